reg_file: RTL

General-purpose register file for the PT1 CPU datapath: DEPTH registers of WIDTH bits, one synchronous write port, two combinational read ports with write-through bypass, and a hardwired-zero register 0. A debug dump engine reads every register out in address order over a valid/ready stream. It is the read-side companion to the latch/flip-flop storage elements: the decode stage reads operands from it, and the writeback stage writes into it.

---
 rtl/reg_file.sv | 92 +++++++++
 1 files changed

// File: rtl/reg_file.sv
// PT1 register file: 1 write port, 2 combinational bypassed read ports, r0 hardwired to zero.
// Debug dump streams every register in address order. Beats are registered, and a beat holds while dump_ready is low.
module reg_file #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [WIDTH-1:0]  regs [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] next_addr;
  logic [WIDTH-1:0]  next_data;
  logic              dump_last;
  logic              beat_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    if (raddr_a == '0)                rdata_a = '0;
    else if (we && waddr == raddr_a)  rdata_a = wdata;
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (raddr_b == '0)                rdata_b = '0;
    else if (we && waddr == raddr_b)  rdata_b = wdata;
  end

  // next_addr is never 0 when it is used, so only the write bypass matters here
  assign next_addr = dump_addr + ADDR_W'(1);
  assign next_data = (we && waddr == next_addr) ? wdata : regs[next_addr];
  assign dump_last = (dump_addr == ADDR_W'(DEPTH - 1));
  assign dump_valid = (state == SEND);
  assign dump_busy  = (state == SEND);
  assign beat_acc   = dump_valid && dump_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dump_addr <= '0;
      dump_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start) begin
            state     <= SEND;
            dump_addr <= '0;
            dump_data <= '0;
          end
        end
        SEND: begin
          if (beat_acc) begin
            if (dump_last) begin
              state <= IDLE;
            end else begin
              dump_addr <= next_addr;
              dump_data <= next_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
